// File: rtl/systolic_movement_output.sv
// ---------------------------------------------------------------------------
// systolic_movement_output
//
// Output-edge de-skew stage for the systolic array, the mirror image of the
// input skew triangle. Column c of the array's bottom edge produces its
// result c cycles after column 0, so lane c is delayed by (NUM_COL-1-c)
// cycles here. Every lane then passes through one common output register,
// and each result row leaves the block as one aligned vector.
//
// The block also tags each aligned vector with its row index inside the
// tile, marks the last row of the tile, and raises a sticky error flag when
// the lanes arrive with a misaligned valid pattern. There is no backpressure
// because the array cannot stall.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   i_data     skewed lane data, lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   i_valid    per-lane valid, skewed the same way as i_data
//   i_clear    synchronous clear of the row counter and the error flag
//   o_data     aligned result vector (registered)
//   o_valid    aligned vector valid (registered)
//   o_last     this vector is row TILE_ROWS-1 of the tile (only with o_valid)
//   o_row_idx  row index of o_data within the tile; holds while o_valid=0
//   o_err      sticky alignment error
// ---------------------------------------------------------------------------
module systolic_movement_output #(
  parameter int NUM_COL    = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_ROWS  = 8,
  parameter int IDX_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_COL*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_COL-1:0]            i_valid,
  input  logic                          i_clear,
  output logic [NUM_COL*DATA_WIDTH-1:0] o_data,
  output logic                          o_valid,
  output logic                          o_last,
  output logic [IDX_W-1:0]              o_row_idx,
  output logic                          o_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_ROWS - 1);

  // Lane data and valid bits as they enter the output register.
  logic [NUM_COL*DATA_WIDTH-1:0] aligned_data;
  logic [NUM_COL-1:0]            aligned_valid;

  logic                          all_ones;
  logic                          mixed;
  logic [IDX_W-1:0]              row_cnt;
  logic [IDX_W-1:0]              cnt_sel;
  logic [IDX_W-1:0]              cnt_inc;

  // Per-lane delay chains. The deepest chain belongs to lane 0, the last
  // lane has none and feeds the output register straight from the input.
  genvar c;
  generate
    for (c = 0; c < NUM_COL; c++) begin : g_lane
      localparam int DEPTH = NUM_COL - 1 - c;
      if (DEPTH == 0) begin : g_direct
        assign aligned_data[c*DATA_WIDTH +: DATA_WIDTH] = i_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign aligned_valid[c] = i_valid[c];
      end else begin : g_chain
        logic [DATA_WIDTH-1:0] data_pipe [DEPTH];
        logic [DEPTH-1:0]      valid_pipe;

        // Shift register of DEPTH stages; reset clears every stage so that
        // nothing in flight survives a reset.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
              data_pipe[i] <= '0;
            end
            valid_pipe <= '0;
          end else begin
            data_pipe[0]  <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
            valid_pipe[0] <= i_valid[c];
            for (int i = 1; i < DEPTH; i++) begin
              data_pipe[i]  <= data_pipe[i-1];
              valid_pipe[i] <= valid_pipe[i-1];
            end
          end
        end

        assign aligned_data[c*DATA_WIDTH +: DATA_WIDTH] = data_pipe[DEPTH-1];
        assign aligned_valid[c] = valid_pipe[DEPTH-1];
      end
    end
  endgenerate

  assign all_ones = &aligned_valid;
  assign mixed    = (|aligned_valid) & ~all_ones;

  // A clear restarts the tile, so the vector registered in the same cycle
  // is numbered as if the counter were already zero. The increment wraps at
  // the last row, which also keeps the counter at zero when TILE_ROWS is 1.
  always_comb begin
    cnt_sel = i_clear ? '0 : row_cnt;
    cnt_inc = (cnt_sel == LAST_IDX) ? '0 : cnt_sel + IDX_W'(1);
  end

  // Output register, row counter and sticky error flag. o_data follows the
  // aligned lanes every cycle; the tag outputs only move on a full vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_row_idx <= '0;
      o_err     <= 1'b0;
      row_cnt   <= '0;
    end else begin
      o_data  <= aligned_data;
      o_valid <= all_ones;
      o_last  <= all_ones && (cnt_sel == LAST_IDX);
      if (all_ones) begin
        o_row_idx <= cnt_sel;
        row_cnt   <= cnt_inc;
      end else if (i_clear) begin
        row_cnt <= '0;
      end
      if (i_clear) begin
        o_err <= 1'b0;
      end else if (mixed) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/systolic_movement_output.md
Name: systolic_movement_output

Overview:
- Output-edge de-skew stage for the systolic array; the counterpart of the input skew triangle.
- Column c of the array's bottom edge emits its result c cycles after column 0. This block delays column c by (NUM_COL-1-c) cycles so each result row leaves as one aligned vector.
- Also tags row index and tile end, and flags misaligned valid patterns.
- Sits between the array bottom edge and the result writer; there is no backpressure because the array cannot stall.

Parameters:
- NUM_COL, 8, number of array columns / output lanes
- DATA_WIDTH, 8, width of one result lane
- TILE_ROWS, 8, aligned result vectors per tile; o_last marks the last one; must be >= 1
- IDX_W, 3, width of o_row_idx; must satisfy 2^IDX_W >= TILE_ROWS

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_data  input  NUM_COL*DATA_WIDTH  skewed lane data; lane c at [c*DATA_WIDTH+:DATA_WIDTH]
- i_valid  input  NUM_COL  per-lane valid, skewed like i_data
- i_clear  input  1  synchronous clear of row counter and error flag
- o_data  output  NUM_COL*DATA_WIDTH  aligned result vector, registered
- o_valid  output  1  aligned vector valid, registered
- o_last  output  1  qualifies o_valid: this vector is row TILE_ROWS-1 of the tile
- o_row_idx  output  IDX_W  row index of the current o_data within the tile
- o_err  output  1  sticky alignment error

Behaviour:
- Reset: clk and rst_n as decided; rst_n low asynchronously zeroes every delay register, o_data, o_valid, o_last, o_row_idx, o_err and the row counter. Reset mid-operation discards in-flight data with no partial output. Dummy data is all-zero.
- Lane c delay chain: (NUM_COL-1-c) registers for data and for valid. Lane NUM_COL-1 has no chain and feeds the output register directly.
- Output register: one stage on all lanes.
- Latency: lane c sampled at cycle t+c appears on o_data at cycle t+NUM_COL, for every c. Throughput is one vector per cycle.
- Aligned valid vector av = the NUM_COL valid bits entering the output register.
- av all ones: o_valid=1 next cycle; o_row_idx = counter; o_last = (counter==TILE_ROWS-1); counter increments, wrapping TILE_ROWS-1 -> 0.
- av all zeros: o_valid=0, o_last=0, counter holds; o_data still updates with the aligned data.
- av mixed: o_valid=0, o_last=0, counter holds; o_err <= 1 (sticky); o_data still updates.
- o_row_idx holds its last value when o_valid=0.
- i_clear=1 has priority over increment and error set. o_err <= 0. The current av is still registered normally. If av is all ones, that vector is emitted as index 0 and counter <= 1 (or 0 if TILE_ROWS==1). Otherwise counter <= 0.
- i_clear does not flush delay chains.
- A mixed av in the i_clear cycle is not recorded in o_err.
- o_last is never 1 while o_valid is 0.
- TILE_ROWS==1: o_last=1 on every valid vector and the counter stays 0.
- NUM_COL==1: no delay chains, latency 1.

Test Plan:
All scenarios use NUM_COL=4, DATA_WIDTH=16, TILE_ROWS=4, IDX_W=2.
- Reset check: hold rst_n low over 3 edges, release -> all outputs 0 and o_err=0; drive i_valid=0 for 10 cycles -> o_valid stays 0.
- Skewed single row: lane c = 16'h0A00+c with valid at cycle 5+c -> cycle 9 has o_valid=1, o_data lanes {0A03,0A02,0A01,0A00}, o_row_idx=0, o_last=0; o_valid=0 on every other cycle.
- Back-to-back tile of 6 rows, skewed streams with row r value 16'h0100*r+c -> o_valid high for 6 consecutive cycles; o_row_idx 0,1,2,3,0,1; o_last only on the 4th; data matches every row.
- Misalignment: lane 2 valid injected one cycle late -> o_valid=0 for the affected vectors, o_err=1 and stays 1; next correctly skewed row is emitted with o_row_idx unchanged from before the fault.
- Clear: assert i_clear while o_err=1, coinciding with an all-ones av -> o_err=0 next cycle; that vector is emitted with o_row_idx=0, and the next row gets index 1.
- Async reset mid-stream: drop rst_n between clock edges during row 2 -> outputs 0 immediately; after release, no stale vector appears and a fresh row gets o_row_idx=0.
